// File: rtl/isa_types.sv
// Shared ISA-level types for the fetch path: memory port control word, fetch queue
// entry and prefetcher state encoding.
package isa_types;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    typedef enum logic [1:0] {
        write_byte,
        write_half,
        write_word
    } mem_width_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            wenable;
        mem_width_e      wwidth;
        logic [XLEN-1:0] wdata;
    } mem_control_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] bits;
    } fetch_entry_t;

    typedef enum logic {
        PF_IDLE,
        PF_PENDING
    } pf_state_e;

endpackage

// File: rtl/instruction_prefetch_queue_if.sv
// Memory-port and instruction-port bundle of the prefetch queue; the master modport
// is the prefetcher side, the slave modport is the memory/consumer environment.
interface instruction_prefetch_queue_if;
    import isa_types::*;

    logic            mem_grant;
    mem_control_t    mem_ctrl;
    logic [XLEN-1:0] mem_rdata;
    logic            instr_valid;
    logic [ILEN-1:0] instr_bits;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        input  mem_grant, mem_rdata, instr_ready, redirect, redirect_pc,
        output mem_ctrl, instr_valid, instr_bits, instr_pc
    );

    modport slave (
        output mem_grant, mem_rdata, instr_ready, redirect, redirect_pc,
        input  mem_ctrl, instr_valid, instr_bits, instr_pc
    );

endinterface

// File: rtl/prefetch_fifo.sv
// DEPTH-entry fetch_entry_t FIFO; head shown combinationally, push visible next cycle.
// No internal backpressure: caller must not push when full; pop on empty is ignored; flush wins.
module prefetch_fifo
    import isa_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_dat,
    input  logic                         pop,
    output fetch_entry_t                 head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/instruction_prefetch_queue.sv
// Sequential instruction prefetcher feeding a small queue; request-to-instr_valid is 2 cycles.
// Issues only while queued plus in-flight words fit; instr_ready stalls the head; redirect flushes.
module instruction_prefetch_queue
    import isa_types::*;
#(
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    instruction_prefetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH+1);

    pf_state_e       state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic            pending, issue, push, pop;
    fetch_entry_t    head;
    fetch_entry_t    resp;
    logic            unused_redirect_lsb;

    assign pending   = (state_q == PF_PENDING);
    // Registered count only: a same-cycle dequeue does not free a slot for issue.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, pending};
    assign issue     = bus.mem_grant && !bus.redirect && (occupancy < (CW+1)'(DEPTH));
    assign push      = pending && !bus.redirect;
    assign pop       = bus.instr_valid && bus.instr_ready && !bus.redirect;
    assign resp      = '{pc: req_pc_q, bits: bus.mem_rdata};

    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

    always_comb begin
        state_d    = PF_IDLE;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
        end else if (issue) begin
            state_d    = PF_PENDING;
            fetch_pc_d = fetch_pc_q + 32'd4;
            req_pc_d   = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PF_IDLE;
            fetch_pc_q <= RESET_VECTOR;
            req_pc_q   <= RESET_VECTOR;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.redirect),
        .push     (push),
        .push_dat (resp),
        .pop      (pop),
        .head_dat (head),
        .count    (count)
    );

    // Read-only port: the address is the fetch pointer whether or not it issues.
    always_comb begin
        bus.mem_ctrl         = '0;
        bus.mem_ctrl.addr    = fetch_pc_q;
        bus.mem_ctrl.wenable = 1'b0;
        bus.mem_ctrl.wwidth  = write_word;
        bus.mem_ctrl.wdata   = '0;
    end

    assign bus.instr_valid = (count != '0);
    assign bus.instr_bits  = head.bits;
    assign bus.instr_pc    = head.pc;

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Scoreboard bench for instruction_prefetch_queue: directed grant/ready/redirect/reset
// sequences push expected pcs; a negedge monitor checks every delivered instruction.
module tb_instruction_prefetch_queue;
    import isa_types::*;

    localparam logic [31:0] RV   = 32'h0;
    localparam logic [31:0] SALT = 32'h5A5A_A5A5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instruction_prefetch_queue_if bus ();

    instruction_prefetch_queue #(
        .DEPTH        (4),
        .RESET_VECTOR (RV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory answers the previous cycle's address one cycle later.
    logic [31:0] last_addr = 32'h0;
    always @(posedge clk) last_addr <= bus.mem_ctrl.addr;
    assign bus.mem_rdata = last_addr ^ SALT;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every accepted instruction must be the next expected one.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ctrl_fields", {31'h0, bus.mem_ctrl.wenable, bus.mem_ctrl.wwidth, bus.mem_ctrl.wdata},
                  {31'h0, 1'b0, write_word, 32'h0});
            if (bus.instr_valid && bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_instr: got pc %h, expected none", bus.instr_pc);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("instr_pc", {32'h0, bus.instr_pc}, {32'h0, e});
                    check("instr_bits", {32'h0, bus.instr_bits}, {32'h0, e ^ SALT});
                end
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus.mem_grant   = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;

        // Reset state
        step(2);
        @(negedge clk);
        check("rst_valid", {63'h0, bus.instr_valid}, 64'h0);
        check("rst_addr", {32'h0, bus.mem_ctrl.addr}, {32'h0, RV});

        // Fill with ready low: four requests then stall
        step(1);
        rst_n = 1'b1;
        bus.mem_grant = 1'b1;
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        step(6);
        @(negedge clk);
        check("fill_valid", {63'h0, bus.instr_valid}, 64'h1);
        check("fill_head_pc", {32'h0, bus.instr_pc}, 64'h0);
        check("fill_stop_addr", {32'h0, bus.mem_ctrl.addr}, 64'h10);
        step(1);
        bus.instr_ready = 1'b1;
        bus.mem_grant   = 1'b0;
        step(5);
        @(negedge clk);
        check("fill_drained", {63'h0, bus.instr_valid}, 64'h0);

        // Steady stream: one instruction per cycle after a two-cycle startup
        step(1);
        bus.mem_grant = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(32'h10 + 32'(4 * k));
        step(2);
        for (int k = 0; k < 8; k++) begin
            if (k == 6) bus.mem_grant = 1'b0;
            @(negedge clk);
            check("stream_valid", {63'h0, bus.instr_valid}, 64'h1);
            check("stream_pc", {32'h0, bus.instr_pc}, {32'h0, 32'h10 + 32'(4 * k)});
            step(1);
        end
        @(negedge clk);
        check("stream_end", {63'h0, bus.instr_valid}, 64'h0);

        // Redirect while at capacity with a response in flight
        step(1);
        bus.mem_grant   = 1'b1;
        bus.instr_ready = 1'b0;
        step(4);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h103;
        @(negedge clk);
        check("pre_redir_pc", {32'h0, bus.instr_pc}, 64'h30);
        step(1);
        bus.redirect  = 1'b0;
        bus.mem_grant = 1'b0;
        @(negedge clk);
        check("redir_empty", {63'h0, bus.instr_valid}, 64'h0);
        check("redir_addr", {32'h0, bus.mem_ctrl.addr}, 64'h100);
        exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
        step(1);
        bus.mem_grant   = 1'b1;
        bus.instr_ready = 1'b1;
        step(3);
        bus.mem_grant = 1'b0;
        step(4);
        @(negedge clk);
        check("redir_drained", {63'h0, bus.instr_valid}, 64'h0);

        // Redirect near the top of memory with grant asserted: address wraps to 0
        step(1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        bus.mem_grant   = 1'b1;
        exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
        step(1);
        bus.redirect = 1'b0;
        @(negedge clk);
        check("wrap_first_addr", {32'h0, bus.mem_ctrl.addr}, 64'hFFFF_FFF8);
        step(3);
        bus.mem_grant = 1'b0;
        @(negedge clk);
        check("wrap_next_addr", {32'h0, bus.mem_ctrl.addr}, 64'h4);
        step(4);
        @(negedge clk);
        check("wrap_drained", {63'h0, bus.instr_valid}, 64'h0);

        // Alternating grant: each response enqueued exactly once
        step(1);
        exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        exp_q.push_back(32'hC); exp_q.push_back(32'h10);
        for (int i = 0; i < 8; i++) begin
            bus.mem_grant = (i % 2 == 0);
            step(1);
        end
        bus.mem_grant = 1'b0;
        step(4);
        @(negedge clk);
        check("toggle_drained", {63'h0, bus.instr_valid}, 64'h0);

        // Reset in the middle of an outstanding request
        step(1);
        bus.mem_grant = 1'b1;
        step(1);
        rst_n = 1'b0;
        bus.mem_grant = 1'b0;
        #1;
        check("midrst_valid", {63'h0, bus.instr_valid}, 64'h0);
        check("midrst_addr", {32'h0, bus.mem_ctrl.addr}, {32'h0, RV});
        exp_q.push_back(RV); exp_q.push_back(RV + 32'h4);
        step(2);
        rst_n = 1'b1;
        bus.mem_grant = 1'b1;
        @(negedge clk);
        check("postrst_addr", {32'h0, bus.mem_ctrl.addr}, {32'h0, RV});
        step(2);
        bus.mem_grant = 1'b0;
        step(5);
        @(negedge clk);
        check("postrst_drained", {63'h0, bus.instr_valid}, 64'h0);

        check("all_delivered", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
